frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, meaning active lines per frame.
REQ-003 SHALL have parameter LEFT_END, default 100, meaning first column of the centre region (left region is x < LEFT_END).
REQ-004 SHALL have parameter RIGHT_START, default 220, meaning first column of the right region.
REQ-005 SHALL have parameter DETECT_THRESH, default 19200, meaning the orange-pixel total above which a frame is flagged (25% of 320x240).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have ports vsync (input, 1, frame sync, high between frames), href (input, 1, line active) and pix_valid (input, 1, pixel qualifier).
REQ-009 SHALL have port is_orange, input, 1, meaning the classifier verdict for the current qualified pixel.
REQ-010 SHALL have ports x (output, 9, current column) and y (output, 8, current line).
REQ-011 SHALL have ports result_valid (output, 1) and result_ready (input, 1) forming the result handshake.
REQ-012 SHALL have ports direction (output, 3), orange_detected (output, 1), orange_total (output, 18), frame_error (output, 1) and overrun (output, 1).

Function
REQ-013 SHALL implement FSM states IDLE, SYNC, ACTIVE and REPORT.
REQ-014 IDLE SHALL move to SYNC on the first cycle vsync=1; SYNC SHALL move to ACTIVE on the first cycle vsync=0.
REQ-015 ACTIVE SHALL move to REPORT on a vsync 0->1 edge (vsync registered once for edge detection); REPORT SHALL last one cycle, then go to SYNC.
REQ-016 A pixel is counted only in ACTIVE with href=1, pix_valid=1, x < H_ACTIVE and y < V_ACTIVE; all other pixels are ignored.
REQ-017 On a counted pixel, x SHALL increment by 1; if is_orange=1, exactly one of left_cnt, centre_cnt or right_cnt (17 bits each, chosen by x region) and the 18-bit total SHALL increment.
REQ-018 On each href 1->0 edge in ACTIVE, x SHALL clear to 0 and y SHALL increment, saturating at 255.
REQ-019 On entry to ACTIVE, x, y and all region/total counters SHALL clear to 0.
REQ-020 In REPORT, the block SHALL latch the frame results and set result_valid=1.
REQ-021 orange_total SHALL equal the total count, and orange_detected SHALL be 1 iff total > DETECT_THRESH.
REQ-022 frame_error SHALL be 1 iff the line count at REPORT differs from V_ACTIVE.
REQ-023 direction SHALL be 3'b000 if total=0; otherwise 3'b001 if left is strictly greatest, 3'b010 if right is strictly greatest, else 3'b011 (centre greatest or any tie).
REQ-024 result_valid SHALL clear on the cycle after result_valid=1 and result_ready=1; latched outputs SHALL hold stable while result_valid=1.
REQ-025 If REPORT occurs while result_valid=1 and result_ready=0, the new results SHALL overwrite the old ones, result_valid SHALL stay 1, and overrun SHALL pulse high for one cycle.
REQ-026 If REPORT coincides with a handshake completing, the new result SHALL win: result_valid stays 1 and overrun stays 0.
REQ-027 Counters SHALL NOT wrap; the region counters and total SHALL saturate at all-ones.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE and x=0, y=0, all counters 0, result_valid=0, direction=000, orange_detected=0, orange_total=0, frame_error=0, overrun=0.
REQ-029 A reset asserted mid-frame SHALL discard that frame; after release, no result is produced until a full SYNC->ACTIVE->REPORT sequence completes.

Verification
REQ-030 The bench SHALL cover this full frame: 240 lines x 320 pixels, orange only at x<100 on every line -> result_valid=1, direction=001, orange_total=24000, orange_detected=1, frame_error=0.
REQ-031 The bench SHALL cover this case: a frame with 10 orange pixels per line in each region -> direction=011, orange_total=7200, orange_detected=0.
REQ-032 The bench SHALL cover this case: a frame of 239 lines -> frame_error=1; pixels with x>=320 on an over-long line are not counted.
REQ-033 The bench SHALL cover this case: result_ready held 0 across two frame ends -> overrun pulses one cycle at the second REPORT, and outputs show the second frame.
REQ-034 The bench SHALL cover this case: rst_n pulsed low at line 120 -> outputs at reset values immediately, with the next result coming only from the following complete frame.
REQ-035 The bench SHALL cover this case: an all-black frame -> direction=000, orange_total=0; pix_valid=0 toggling mid-line does not advance x.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame sequencer: tallies orange pixels per horizontal region over a frame
// and publishes direction/total through a valid/ready result port.
module frame_sequencer #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int LEFT_END      = 100,
  parameter int RIGHT_START   = 220,
  parameter int DETECT_THRESH = 19200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        href,
  input  logic        pix_valid,
  input  logic        is_orange,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [2:0]  direction,
  output logic        orange_detected,
  output logic [17:0] orange_total,
  output logic        frame_error,
  output logic        overrun
);

  localparam logic [8:0]  HMAX   = 9'(H_ACTIVE);
  localparam logic [7:0]  VMAX   = 8'(V_ACTIVE);
  localparam logic [8:0]  LEND   = 9'(LEFT_END);
  localparam logic [8:0]  RSTART = 9'(RIGHT_START);
  localparam logic [17:0] THR    = 18'(DETECT_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE,
    REPORT
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, href_q;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [16:0] left_q, left_d;
  logic [16:0] centre_q, centre_d;
  logic [16:0] right_q, right_d;
  logic [17:0] total_q, total_d;
  logic        rv_q, rv_d;
  logic [2:0]  dir_q, dir_d;
  logic        det_q, det_d;
  logic [17:0] res_tot_q, res_tot_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic        pix_ok;
  logic        in_left, in_right;
  logic [2:0]  dir_c;

  function automatic logic [16:0] inc17(input logic [16:0] v);
    return (&v) ? v : v + 17'd1;
  endfunction

  assign pix_ok   = (state_q == ACTIVE) && href && pix_valid &&
                    (x_q < HMAX) && (y_q < VMAX);
  assign in_left  = x_q < LEND;
  assign in_right = x_q >= RSTART;

  // Ties and a centre lead both report straight ahead.
  always_comb begin
    dir_c = 3'b011;
    if (total_q == '0)
      dir_c = 3'b000;
    else if (left_q > centre_q && left_q > right_q)
      dir_c = 3'b001;
    else if (right_q > left_q && right_q > centre_q)
      dir_c = 3'b010;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    left_d    = left_q;
    centre_d  = centre_q;
    right_d   = right_q;
    total_d   = total_q;
    rv_d      = rv_q;
    dir_d     = dir_q;
    det_d     = det_q;
    res_tot_d = res_tot_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    if (rv_q && result_ready)
      rv_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vsync)
          state_d = SYNC;
      end
      SYNC: begin
        if (!vsync) begin
          state_d  = ACTIVE;
          x_d      = '0;
          y_d      = '0;
          left_d   = '0;
          centre_d = '0;
          right_d  = '0;
          total_d  = '0;
        end
      end
      ACTIVE: begin
        if (pix_ok) begin
          x_d = x_q + 9'd1;
          if (is_orange) begin
            total_d = (&total_q) ? total_q : total_q + 18'd1;
            unique case (1'b1)
              in_left:  left_d   = inc17(left_q);
              in_right: right_d  = inc17(right_q);
              default:  centre_d = inc17(centre_q);
            endcase
          end
        end
        if (href_q && !href) begin
          x_d = '0;
          y_d = (&y_q) ? y_q : y_q + 8'd1;
        end
        if (vsync && !vsync_q)
          state_d = REPORT;
      end
      REPORT: begin
        // A fresh frame always replaces whatever is still pending.
        state_d   = SYNC;
        rv_d      = 1'b1;
        dir_d     = dir_c;
        det_d     = total_q > THR;
        res_tot_d = total_q;
        ferr_d    = y_q != VMAX;
        ovr_d     = rv_q && !result_ready;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      left_q    <= '0;
      centre_q  <= '0;
      right_q   <= '0;
      total_q   <= '0;
      rv_q      <= 1'b0;
      dir_q     <= 3'b000;
      det_q     <= 1'b0;
      res_tot_q <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      href_q    <= href;
      x_q       <= x_d;
      y_q       <= y_d;
      left_q    <= left_d;
      centre_q  <= centre_d;
      right_q   <= right_d;
      total_q   <= total_d;
      rv_q      <= rv_d;
      dir_q     <= dir_d;
      det_q     <= det_d;
      res_tot_q <= res_tot_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign result_valid    = rv_q;
  assign direction       = dir_q;
  assign orange_detected = det_q;
  assign orange_total    = res_tot_q;
  assign frame_error     = ferr_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench: full-size instance for the 320x240 frame, narrow instance
// (40-pixel lines) for the remaining frame-level cases.
module tb_frame_sequencer;

  typedef enum int {
    M_BLACK,
    M_ALL,
    M_LEFT,
    M_CENTRE,
    M_RIGHT,
    M_TIE
  } mode_t;

  typedef struct {
    int    d;
    int    lines;
    int    len;
    int    len0;
    mode_t mode;
    bit    pause;
    int    dir;
    int    tot;
    int    det;
    int    ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn  [2];
  logic        vsync [2];
  logic        href  [2];
  logic        pv    [2];
  logic        org   [2];
  logic        rdy   [2];
  logic [8:0]  xo    [2];
  logic [7:0]  yo    [2];
  logic        rv    [2];
  logic [2:0]  dir   [2];
  logic        det   [2];
  logic [17:0] tot   [2];
  logic        ferr  [2];
  logic        ovr   [2];

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vt [6];
  vec_t sb_a [$];
  vec_t sb_b [$];

  always #5 clk = ~clk;

  frame_sequencer u_a (
    .clk(clk), .rst_n(rstn[0]), .vsync(vsync[0]), .href(href[0]),
    .pix_valid(pv[0]), .is_orange(org[0]), .x(xo[0]), .y(yo[0]),
    .result_valid(rv[0]), .result_ready(rdy[0]), .direction(dir[0]),
    .orange_detected(det[0]), .orange_total(tot[0]),
    .frame_error(ferr[0]), .overrun(ovr[0])
  );

  frame_sequencer #(
    .H_ACTIVE(40), .V_ACTIVE(240), .LEFT_END(12),
    .RIGHT_START(28), .DETECT_THRESH(19200)
  ) u_b (
    .clk(clk), .rst_n(rstn[1]), .vsync(vsync[1]), .href(href[1]),
    .pix_valid(pv[1]), .is_orange(org[1]), .x(xo[1]), .y(yo[1]),
    .result_valid(rv[1]), .result_ready(rdy[1]), .direction(dir[1]),
    .orange_detected(det[1]), .orange_total(tot[1]),
    .frame_error(ferr[1]), .overrun(ovr[1])
  );

  task automatic chk(input string nm, input int d,
                     input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, d, act, exp);
  endtask

  function automatic logic orange(input int d, input mode_t m,
                                  input int i);
    int h, le, rs;
    h  = (d == 0) ? 320 : 40;
    le = (d == 0) ? 100 : 12;
    rs = (d == 0) ? 220 : 28;
    case (m)
      M_ALL:    return 1'b1;
      M_LEFT:   return (i < le) || (i >= h);
      M_CENTRE: return (i >= le) && (i < rs);
      M_RIGHT:  return i >= rs;
      M_TIE:    return (i < 10) || (i >= le && i < le + 10) ||
                       (i >= rs && i < rs + 10);
      default:  return 1'b0;
    endcase
  endfunction

  task automatic push(input int d, input vec_t v);
    if (d == 0) sb_a.push_back(v);
    else        sb_b.push_back(v);
  endtask

  task automatic pop(input int d, output vec_t v);
    int sz;
    sz = (d == 0) ? sb_a.size() : sb_b.size();
    chk("sb_nonempty", d, int'(sz > 0), 1);
    v = '{d, 0, 0, 0, M_BLACK, 1'b0, -1, -1, -1, -1};
    if (sz > 0) begin
      if (d == 0) v = sb_a.pop_front();
      else        v = sb_b.pop_front();
    end
  endtask

  task automatic drive_lines(input int d, input vec_t v);
    for (int l = 0; l < v.lines; l++) begin
      int len;
      len = (l == 0) ? v.len0 : v.len;
      for (int i = 0; i < len; i++) begin
        if (v.pause && l == 0 && i == 5) begin
          href[d] = 1'b1; pv[d] = 1'b0; org[d] = 1'b1;
          repeat (3) @(negedge clk);
          chk("pause_x", d, int'(xo[d]), 5);
        end
        href[d] = 1'b1; pv[d] = 1'b1;
        org[d]  = orange(d, v.mode, i);
        @(negedge clk);
      end
      href[d] = 1'b0; pv[d] = 1'b0; org[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input int d, input vec_t v);
    vsync[d] = 1'b1; href[d] = 1'b0; pv[d] = 1'b0; org[d] = 1'b0;
    repeat (3) @(negedge clk);
    vsync[d] = 1'b0;
    repeat (2) @(negedge clk);
    drive_lines(d, v);
    vsync[d] = 1'b1;
  endtask

  task automatic wait_rv(input int d);
    int n;
    n = 0;
    while (rv[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rv_set", d, int'(rv[d]), 1);
  endtask

  task automatic cmp(input int d, input vec_t e);
    chk("direction", d, int'(dir[d]), e.dir);
    chk("orange_total", d, int'(tot[d]), e.tot);
    chk("orange_detected", d, int'(det[d]), e.det);
    chk("frame_error", d, int'(ferr[d]), e.ferr);
  endtask

  task automatic get_result(input int d);
    vec_t e;
    wait_rv(d);
    pop(d, e);
    cmp(d, e);
    chk("overrun_idle", d, int'(ovr[d]), 0);
    rdy[d] = 1'b1;
    @(negedge clk);
    rdy[d] = 1'b0;
    chk("rv_clear", d, int'(rv[d]), 0);
  endtask

  task automatic seq_overrun();
    vec_t f1, f2, e;
    f1 = '{1, 4, 40, 40, M_ALL, 1'b0, 3, 160, 0, 1};
    f2 = '{1, 3, 40, 40, M_LEFT, 1'b0, 1, 36, 0, 1};
    rdy[1] = 1'b0;
    drive_frame(1, f1);
    push(1, f1);
    wait_rv(1);
    pop(1, e);
    cmp(1, e);
    drive_frame(1, f2);
    push(1, f2);
    chk("hold_total", 1, int'(tot[1]), 160);
    chk("hold_rv", 1, int'(rv[1]), 1);
    @(negedge clk);
    chk("ovr_early", 1, int'(ovr[1]), 0);
    @(negedge clk);
    chk("ovr_pulse", 1, int'(ovr[1]), 1);
    chk("rv_kept", 1, int'(rv[1]), 1);
    pop(1, e);
    cmp(1, e);
    @(negedge clk);
    chk("ovr_one_cycle", 1, int'(ovr[1]), 0);
  endtask

  task automatic seq_reset();
    vec_t p, f3;
    int   seen;
    p  = '{1, 120, 40, 40, M_ALL, 1'b0, 0, 0, 0, 0};
    f3 = '{1, 2, 40, 40, M_ALL, 1'b0, 3, 80, 0, 1};
    vsync[1] = 1'b1;
    repeat (3) @(negedge clk);
    vsync[1] = 1'b0;
    repeat (2) @(negedge clk);
    drive_lines(1, p);
    chk("y_before_rst", 1, int'(yo[1]), 120);
    chk("tot_before_rst", 1, int'(tot[1]), 36);
    rstn[1] = 1'b0;
    #1;
    chk("rst_y", 1, int'(yo[1]), 0);
    chk("rst_rv", 1, int'(rv[1]), 0);
    chk("rst_total", 1, int'(tot[1]), 0);
    chk("rst_dir", 1, int'(dir[1]), 0);
    chk("rst_ferr", 1, int'(ferr[1]), 0);
    @(negedge clk);
    rstn[1] = 1'b1;
    p.lines = 5;
    drive_lines(1, p);
    vsync[1] = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv[1] === 1'b1) seen++;
    end
    chk("no_result_after_rst", 1, seen, 0);
    drive_frame(1, f3);
    push(1, f3);
    get_result(1);
  endtask

  task automatic seq_coincide();
    vec_t f4, f5, e;
    f4 = '{1, 1, 40, 40, M_LEFT, 1'b0, 1, 12, 0, 1};
    f5 = '{1, 2, 40, 40, M_RIGHT, 1'b0, 2, 24, 0, 1};
    drive_frame(1, f4);
    push(1, f4);
    wait_rv(1);
    pop(1, e);
    cmp(1, e);
    drive_frame(1, f5);
    push(1, f5);
    @(negedge clk);
    rdy[1] = 1'b1;
    @(negedge clk);
    rdy[1] = 1'b0;
    chk("coincide_rv", 1, int'(rv[1]), 1);
    chk("coincide_ovr", 1, int'(ovr[1]), 0);
    pop(1, e);
    cmp(1, e);
    rdy[1] = 1'b1;
    @(negedge clk);
    rdy[1] = 1'b0;
    chk("coincide_ack", 1, int'(rv[1]), 0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{0, 240, 320, 330, M_LEFT,   1'b0, 1, 24000, 1, 0};
    vt[1] = '{1, 240,  40,  40, M_TIE,    1'b0, 3,  7200, 0, 0};
    vt[2] = '{1, 239,  45,  45, M_RIGHT,  1'b0, 2,  2868, 0, 1};
    vt[3] = '{1, 240,  40,  40, M_BLACK,  1'b1, 0,     0, 0, 0};
    vt[4] = '{1, 240,  40,  40, M_CENTRE, 1'b0, 3,  3840, 0, 0};
    vt[5] = '{1, 240,  40,  40, M_LEFT,   1'b0, 1,  2880, 0, 0};
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; vsync[d] = 1'b0; href[d] = 1'b0;
      pv[d] = 1'b0; org[d] = 1'b0; rdy[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_x", d, int'(xo[d]), 0);
      chk("reset_y", d, int'(yo[d]), 0);
      chk("reset_rv", d, int'(rv[d]), 0);
      chk("reset_total", d, int'(tot[d]), 0);
      chk("reset_det", d, int'(det[d]), 0);
      chk("reset_ovr", d, int'(ovr[d]), 0);
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(negedge clk);
    fork
      begin
        drive_frame(0, vt[0]);
        push(0, vt[0]);
        get_result(0);
      end
      begin
        for (int k = 1; k < 6; k++) begin
          drive_frame(1, vt[k]);
          push(1, vt[k]);
          get_result(1);
        end
        seq_overrun();
        seq_reset();
        seq_coincide();
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
